// File: rtl/mapper_pkg.sv
// Shared constants and types for the discrete NES mapper register slice.
package mapper_pkg;

  localparam int unsigned MODE_UXROM = 0;
  localparam int unsigned MODE_CNROM = 1;
  localparam int unsigned MODE_AXROM = 2;

  localparam int unsigned CPU_DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_COMMIT = 2'd2
  } wr_state_e;

endpackage

// File: rtl/romsel_sync.sv
// Brings romsel/rw into the clk domain, delays bus data by the same depth,
// and flags the synced romsel rising edge.
module romsel_sync #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned DW     = 16
) (
  input  logic          clk,
  input  logic          Nrst,
  input  logic          romsel_raw,
  input  logic          rw_raw,
  input  logic [DW-1:0] data_raw,
  output logic          romsel_s,
  output logic          rw_s,
  output logic          romsel_rise_c,
  output logic [DW-1:0] data_s
);

  logic [STAGES-1:0] romsel_q;
  logic [STAGES-1:0] rw_q;
  logic [DW-1:0]     data_q [STAGES];
  logic              romsel_prev;

  always_ff @(posedge clk) begin
    if (!Nrst) begin
      romsel_q    <= '1;
      rw_q        <= '1;
      romsel_prev <= 1'b1;
      for (int i = 0; i < int'(STAGES); i++) data_q[i] <= '0;
    end else begin
      romsel_q    <= {romsel_q[STAGES-2:0], romsel_raw};
      rw_q        <= {rw_q[STAGES-2:0], rw_raw};
      romsel_prev <= romsel_q[STAGES-1];
      data_q[0]   <= data_raw;
      for (int i = 1; i < int'(STAGES); i++) data_q[i] <= data_q[i-1];
    end
  end

  assign romsel_s      = romsel_q[STAGES-1];
  assign rw_s          = rw_q[STAGES-1];
  assign data_s        = data_q[STAGES-1];
  assign romsel_rise_c = romsel_q[STAGES-1] & ~romsel_prev;

endmodule

// File: rtl/discrete_mapper_reg.sv
// Bank/mirroring register for UxROM, CNROM and AxROM discrete mappers,
// written by CPU stores to $8000-$FFFF and committed on the romsel rising edge.
module discrete_mapper_reg
  import mapper_pkg::*;
#(
  parameter int unsigned MODE         = 0,
  parameter int unsigned PRG_BITS     = 4,
  parameter int unsigned CHR_BITS     = 2,
  parameter int unsigned BUS_CONFLICT = 0,
  parameter int unsigned MIRROR       = 1,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                clk,
  input  logic                Nrst,
  input  logic [CPU_DW-1:0]   cpu_d,
  input  logic                cpu_rw,
  input  logic                Ncpu_romsel,
  input  logic                cpu_a14,
  input  logic [CPU_DW-1:0]   rom_d,
  input  logic                ppu_a10,
  input  logic                ppu_a11,
  output logic [PRG_BITS-1:0] prg_a,
  output logic [CHR_BITS-1:0] chr_a,
  output logic                ciram_a10,
  output logic                wr_strobe
);

  localparam int unsigned SDW = 2 * CPU_DW;

  logic              romsel_s;
  logic              rw_s;
  logic              romsel_rise_c;
  logic [SDW-1:0]    data_s;
  logic [CPU_DW-1:0] sample_c;
  logic [CPU_DW-1:0] sample;

  wr_state_e state;
  wr_state_e state_next;
  logic      capture_c;
  logic      commit_c;

  logic [PRG_BITS-1:0] bank;
  logic [CHR_BITS-1:0] chr;
  logic                mir;

  romsel_sync #(
    .STAGES (SYNC_STAGES),
    .DW     (SDW)
  ) u_sync (
    .clk           (clk),
    .Nrst          (Nrst),
    .romsel_raw    (Ncpu_romsel),
    .rw_raw        (cpu_rw),
    .data_raw      ({cpu_d, rom_d}),
    .romsel_s      (romsel_s),
    .rw_s          (rw_s),
    .romsel_rise_c (romsel_rise_c),
    .data_s        (data_s)
  );

  // Value the cartridge latch actually sees on the bus
  assign sample_c = (BUS_CONFLICT != 0) ? (data_s[SDW-1:CPU_DW] & data_s[CPU_DW-1:0])
                                        : data_s[SDW-1:CPU_DW];

  always_ff @(posedge clk) begin
    if (!Nrst) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Capture only while romsel is still low, so the sample taken just before the rise wins
  always_comb begin
    state_next = state;
    capture_c  = 1'b0;
    commit_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!romsel_s && !rw_s) begin
          state_next = ST_WRITE;
          capture_c  = 1'b1;
        end
      end
      ST_WRITE: begin
        if (romsel_rise_c)           state_next = ST_COMMIT;
        else if (!romsel_s && !rw_s) capture_c  = 1'b1;
        else                         state_next = ST_IDLE;
      end
      ST_COMMIT: begin
        commit_c   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!Nrst) begin
      sample    <= '0;
      bank      <= '0;
      chr       <= '0;
      mir       <= 1'b0;
      wr_strobe <= 1'b0;
    end else begin
      wr_strobe <= commit_c;
      if (capture_c) sample <= sample_c;
      if (commit_c) begin
        if (MODE == MODE_UXROM) begin
          bank <= PRG_BITS'(sample);
        end else if (MODE == MODE_CNROM) begin
          chr <= CHR_BITS'(sample);
        end else begin
          bank <= PRG_BITS'(sample[PRG_BITS-2:0]);
          mir  <= sample[4];
        end
      end
    end
  end

  // Address path is purely combinational from the registers
  always_comb begin
    prg_a     = '0;
    chr_a     = '0;
    ciram_a10 = (MIRROR != 0) ? ppu_a10 : ppu_a11;
    if (MODE == MODE_UXROM) begin
      prg_a = cpu_a14 ? '1 : bank;
    end else if (MODE == MODE_CNROM) begin
      prg_a = PRG_BITS'(cpu_a14);
      chr_a = chr;
    end else begin
      prg_a     = {bank[PRG_BITS-2:0], cpu_a14};
      ciram_a10 = mir;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{sample, bank, chr, mir};

endmodule

// File: tb/tb_discrete_mapper_reg.sv
// Scoreboard bench: four mapper flavours share one CPU/PPU bus; expected
// register values are queued per write and checked on each wr_strobe.
module tb_discrete_mapper_reg;

  logic       clk;
  logic       Nrst;
  logic [7:0] cpu_d;
  logic       cpu_rw;
  logic       Ncpu_romsel;
  logic       cpu_a14;
  logic [7:0] rom_d;
  logic       ppu_a10;
  logic       ppu_a11;

  logic [3:0] u0_prg, ub_prg, u1_prg, u2_prg;
  logic [1:0] u0_chr, ub_chr, u1_chr, u2_chr;
  logic       u0_cir, ub_cir, u1_cir, u2_cir;
  logic       u0_stb, ub_stb, u1_stb, u2_stb;

  int checks = 0;
  int errors = 0;
  int cnt0 = 0, cntb = 0, cnt1 = 0, cnt2 = 0;
  logic p0 = 1'b0, pb = 1'b0, p1 = 1'b0, p2 = 1'b0;

  logic [3:0] q0[$];
  logic [3:0] qb[$];
  logic [1:0] q1[$];
  logic [3:0] q2[$];

  logic [3:0] m0 = '0, mb = '0, m2b = '0;
  logic [1:0] m1 = '0;
  logic       m2m = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  discrete_mapper_reg #(.MODE(0), .PRG_BITS(4), .CHR_BITS(2), .BUS_CONFLICT(0), .MIRROR(1), .SYNC_STAGES(2)) u0 (
    .clk(clk), .Nrst(Nrst), .cpu_d(cpu_d), .cpu_rw(cpu_rw), .Ncpu_romsel(Ncpu_romsel), .cpu_a14(cpu_a14),
    .rom_d(rom_d), .ppu_a10(ppu_a10), .ppu_a11(ppu_a11), .prg_a(u0_prg), .chr_a(u0_chr),
    .ciram_a10(u0_cir), .wr_strobe(u0_stb));

  discrete_mapper_reg #(.MODE(0), .PRG_BITS(4), .CHR_BITS(2), .BUS_CONFLICT(1), .MIRROR(1), .SYNC_STAGES(2)) ub (
    .clk(clk), .Nrst(Nrst), .cpu_d(cpu_d), .cpu_rw(cpu_rw), .Ncpu_romsel(Ncpu_romsel), .cpu_a14(cpu_a14),
    .rom_d(rom_d), .ppu_a10(ppu_a10), .ppu_a11(ppu_a11), .prg_a(ub_prg), .chr_a(ub_chr),
    .ciram_a10(ub_cir), .wr_strobe(ub_stb));

  discrete_mapper_reg #(.MODE(1), .PRG_BITS(4), .CHR_BITS(2), .BUS_CONFLICT(0), .MIRROR(0), .SYNC_STAGES(2)) u1 (
    .clk(clk), .Nrst(Nrst), .cpu_d(cpu_d), .cpu_rw(cpu_rw), .Ncpu_romsel(Ncpu_romsel), .cpu_a14(cpu_a14),
    .rom_d(rom_d), .ppu_a10(ppu_a10), .ppu_a11(ppu_a11), .prg_a(u1_prg), .chr_a(u1_chr),
    .ciram_a10(u1_cir), .wr_strobe(u1_stb));

  discrete_mapper_reg #(.MODE(2), .PRG_BITS(4), .CHR_BITS(2), .BUS_CONFLICT(0), .MIRROR(1), .SYNC_STAGES(2)) u2 (
    .clk(clk), .Nrst(Nrst), .cpu_d(cpu_d), .cpu_rw(cpu_rw), .Ncpu_romsel(Ncpu_romsel), .cpu_a14(cpu_a14),
    .rom_d(rom_d), .ppu_a10(ppu_a10), .ppu_a11(ppu_a11), .prg_a(u2_prg), .chr_a(u2_chr),
    .ciram_a10(u2_cir), .wr_strobe(u2_stb));

  // Scoreboard: every strobe pops the oldest expected value of that instance
  always @(negedge clk) begin
    logic [3:0] e;
    logic [1:0] ec;
    if (u0_stb) begin
      cnt0++;
      checks++;
      if (p0) begin errors++; $display("FAIL u0_strobe_width: strobe high on consecutive cycles"); end
      checks++;
      if (q0.size() == 0) begin errors++; $display("FAIL u0_unexpected_strobe: got strobe, expected none"); end
      else begin
        e = q0.pop_front();
        if (u0_prg !== e) begin errors++; $display("FAIL u0_commit: prg_a=%0d expected %0d", u0_prg, e); end
      end
    end
    if (ub_stb) begin
      cntb++;
      checks++;
      if (qb.size() == 0) begin errors++; $display("FAIL ub_unexpected_strobe: got strobe, expected none"); end
      else begin
        e = qb.pop_front();
        if (ub_prg !== e) begin errors++; $display("FAIL ub_commit: prg_a=%0d expected %0d", ub_prg, e); end
      end
    end
    if (u1_stb) begin
      cnt1++;
      checks++;
      if (p1) begin errors++; $display("FAIL u1_strobe_width: strobe high on consecutive cycles"); end
      checks++;
      if (q1.size() == 0) begin errors++; $display("FAIL u1_unexpected_strobe: got strobe, expected none"); end
      else begin
        ec = q1.pop_front();
        if (u1_chr !== ec) begin errors++; $display("FAIL u1_commit: chr_a=%0d expected %0d", u1_chr, ec); end
      end
    end
    if (u2_stb) begin
      cnt2++;
      checks++;
      if (q2.size() == 0) begin errors++; $display("FAIL u2_unexpected_strobe: got strobe, expected none"); end
      else begin
        e = q2.pop_front();
        if (u2_prg !== {e[2:0], 1'b0} || u2_cir !== e[3]) begin
          errors++;
          $display("FAIL u2_commit: prg_a=%0d ciram=%0b expected prg_a=%0d ciram=%0b",
                   u2_prg, u2_cir, {e[2:0], 1'b0}, e[3]);
        end
      end
    end
    p0 = u0_stb; pb = ub_stb; p1 = u1_stb; p2 = u2_stb;
  end

  task automatic cpu_write(input logic [7:0] d);
    logic [7:0] t;
    logic [3:0] old0;
    t = d & rom_d;
    q0.push_back(d[3:0]);
    qb.push_back(t[3:0]);
    q1.push_back(d[1:0]);
    q2.push_back({d[4], d[2:0]});
    old0 = m0;
    @(negedge clk);
    cpu_d = d; cpu_rw = 1'b0; Ncpu_romsel = 1'b0;
    repeat (6) @(negedge clk);
    Ncpu_romsel = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 2) begin cpu_rw = 1'b1; cpu_d = 8'($urandom); end
      if (i == 3) begin
        checks++;
        if (u0_prg !== old0) begin errors++; $display("FAIL latency_early: prg_a=%0d expected %0d", u0_prg, old0); end
      end
      if (i == 4) begin
        checks++;
        if (u0_prg !== d[3:0] || u0_stb !== 1'b1) begin
          errors++;
          $display("FAIL latency_commit: prg_a=%0d strobe=%0b expected %0d strobe=1", u0_prg, u0_stb, d[3:0]);
        end
      end
    end
    m0 = d[3:0]; mb = t[3:0]; m1 = d[1:0]; m2b = {1'b0, d[2:0]}; m2m = d[4];
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((q0.size() + qb.size() + q1.size() + q2.size()) != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ((q0.size() + qb.size() + q1.size() + q2.size()) != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d commits outstanding, expected 0", tag, q0.size() + qb.size() + q1.size() + q2.size());
      q0.delete(); qb.delete(); q1.delete(); q2.delete();
    end
  endtask

  task automatic check_idle_state(input string tag);
    checks++;
    if (u0_prg !== m0 || ub_prg !== mb || u1_chr !== m1 || u2_prg !== {m2b[2:0], 1'b0} || u2_cir !== m2m) begin
      errors++;
      $display("FAIL %s: u0=%0d ub=%0d u1chr=%0d u2=%0d u2cir=%0b expected %0d %0d %0d %0d %0b",
               tag, u0_prg, ub_prg, u1_chr, u2_prg, u2_cir, m0, mb, m1, {m2b[2:0], 1'b0}, m2m);
    end
  endtask

  task automatic test_reset();
    Nrst = 1'b0;
    repeat (3) @(negedge clk);
    cpu_a14 = 1'b0;
    #1;
    checks++;
    if (u0_prg !== 4'd0 || u2_prg !== 4'd0 || u1_chr !== 2'd0 || u2_cir !== 1'b0 || u1_prg !== 4'd0) begin
      errors++;
      $display("FAIL reset_a14_0: u0=%0d u2=%0d u1chr=%0d u2cir=%0b u1=%0d expected 0 0 0 0 0",
               u0_prg, u2_prg, u1_chr, u2_cir, u1_prg);
    end
    checks++;
    if ({u0_stb, ub_stb, u1_stb, u2_stb} !== 4'b0) begin
      errors++; $display("FAIL reset_strobe: strobes=%b expected 0000", {u0_stb, ub_stb, u1_stb, u2_stb});
    end
    cpu_a14 = 1'b1;
    #1;
    checks++;
    if (u0_prg !== 4'hF || u1_prg !== 4'd1 || u2_prg !== 4'd1) begin
      errors++; $display("FAIL reset_a14_1: u0=%0d u1=%0d u2=%0d expected 15 1 1", u0_prg, u1_prg, u2_prg);
    end
    cpu_a14 = 1'b0;
    @(negedge clk);
    Nrst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_uxrom_write();
    int c0;
    c0 = cnt0;
    cpu_write(8'h05);
    drain("uxrom");
    cpu_a14 = 1'b0; #1;
    checks++;
    if (u0_prg !== 4'd5) begin errors++; $display("FAIL uxrom_lo: prg_a=%0d expected 5", u0_prg); end
    cpu_a14 = 1'b1; #1;
    checks++;
    if (u0_prg !== 4'd15) begin errors++; $display("FAIL uxrom_hi: prg_a=%0d expected 15", u0_prg); end
    cpu_a14 = 1'b0;
    checks++;
    if (cnt0 - c0 != 1) begin errors++; $display("FAIL uxrom_strobes: %0d strobes expected 1", cnt0 - c0); end
  endtask

  task automatic test_bus_conflict();
    rom_d = 8'h06;
    cpu_write(8'h0F);
    drain("bus_conflict");
    rom_d = 8'hFF;
    checks++;
    if (ub_prg !== 4'd6 || u0_prg !== 4'hF) begin
      errors++; $display("FAIL bus_conflict: ub=%0d u0=%0d expected 6 15", ub_prg, u0_prg);
    end
  endtask

  task automatic test_abort_and_read();
    int c0;
    c0 = cnt0 + cntb + cnt1 + cnt2;
    @(negedge clk);
    cpu_d = 8'h0A; cpu_rw = 1'b0; Ncpu_romsel = 1'b0;
    repeat (3) @(negedge clk);
    cpu_rw = 1'b1;
    repeat (3) @(negedge clk);
    Ncpu_romsel = 1'b1;
    repeat (8) @(negedge clk);
    cpu_d = 8'h09; Ncpu_romsel = 1'b0;
    repeat (6) @(negedge clk);
    Ncpu_romsel = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (cnt0 + cntb + cnt1 + cnt2 != c0) begin
      errors++; $display("FAIL abort_read_strobes: %0d strobes expected 0", cnt0 + cntb + cnt1 + cnt2 - c0);
    end
    check_idle_state("abort_read_unchanged");
  endtask

  task automatic test_axrom();
    cpu_write(8'h13);
    drain("axrom1");
    cpu_a14 = 1'b0; #1;
    checks++;
    if (u2_prg !== 4'd6 || u2_cir !== 1'b1) begin
      errors++; $display("FAIL axrom_13_lo: prg_a=%0d ciram=%0b expected 6 1", u2_prg, u2_cir);
    end
    cpu_a14 = 1'b1; #1;
    checks++;
    if (u2_prg !== 4'd7) begin errors++; $display("FAIL axrom_13_hi: prg_a=%0d expected 7", u2_prg); end
    cpu_a14 = 1'b0;
    cpu_write(8'h00);
    drain("axrom2");
    checks++;
    if (u2_prg !== 4'd0 || u2_cir !== 1'b0) begin
      errors++; $display("FAIL axrom_00: prg_a=%0d ciram=%0b expected 0 0", u2_prg, u2_cir);
    end
  endtask

  task automatic test_back_to_back();
    int c1;
    c1 = cnt1;
    cpu_write(8'h03);
    cpu_write(8'hFE);
    drain("b2b");
    checks++;
    if (u1_chr !== 2'd2 || cnt1 - c1 != 2) begin
      errors++; $display("FAIL b2b_chr: chr_a=%0d strobes=%0d expected 2 and 2", u1_chr, cnt1 - c1);
    end
    for (int k = 0; k < 6; k++) cpu_write(8'($urandom));
    drain("random");
    check_idle_state("random_final");
  endtask

  task automatic test_mirroring();
    for (int k = 0; k < 4; k++) begin
      ppu_a10 = k[0]; ppu_a11 = k[1];
      #1;
      checks++;
      if (u0_cir !== ppu_a10 || u1_cir !== ppu_a11 || u2_cir !== m2m) begin
        errors++;
        $display("FAIL mirroring_%0d: u0=%0b u1=%0b u2=%0b expected %0b %0b %0b",
                 k, u0_cir, u1_cir, u2_cir, ppu_a10, ppu_a11, m2m);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int c0;
    c0 = cnt0 + cntb + cnt1 + cnt2;
    @(negedge clk);
    cpu_d = 8'h07; cpu_rw = 1'b0; Ncpu_romsel = 1'b0;
    repeat (6) @(negedge clk);
    Ncpu_romsel = 1'b1;
    @(negedge clk);
    Nrst = 1'b0;
    repeat (2) @(negedge clk);
    Nrst = 1'b1;
    cpu_rw = 1'b1;
    m0 = '0; mb = '0; m1 = '0; m2b = '0; m2m = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (cnt0 + cntb + cnt1 + cnt2 != c0) begin
      errors++; $display("FAIL reset_mid_strobes: %0d strobes expected 0", cnt0 + cntb + cnt1 + cnt2 - c0);
    end
    check_idle_state("reset_mid_banks");
  endtask

  initial begin
    Nrst = 1'b0; cpu_d = '0; cpu_rw = 1'b1; Ncpu_romsel = 1'b1; cpu_a14 = 1'b0;
    rom_d = 8'hFF; ppu_a10 = 1'b0; ppu_a11 = 1'b0;
    test_reset();
    test_uxrom_write();
    test_bus_conflict();
    test_abort_and_read();
    test_axrom();
    test_back_to_back();
    test_mirroring();
    test_reset_mid_write();
    test_mirroring();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
